// File: rtl/conv_top.sv
// Self-contained 3x3 valid-mode convolution over an internally held 8x8 image.
// Emits the 6x6 feature map row-major, one registered result per clock, then parks in DONE.
module conv_top (
  input  logic        clk,
  input  logic        rst,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [2:0]  out_row,
  output logic [2:0]  out_col,
  output logic        done
);

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int PIX_W = 8;
  localparam int ACC_W = 16;
  localparam int K     = 3;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam logic [2:0] LAST_COL = 3'(IMG_W - K);
  localparam logic [2:0] LAST_ROW = 3'(IMG_H - K);

  // Row-major 3x3 Sobel-style horizontal gradient kernel.
  localparam logic signed [3:0] KERNEL [K*K] = '{
    4'sd1, 4'sd0, -4'sd1,
    4'sd2, 4'sd0, -4'sd2,
    4'sd1, 4'sd0, -4'sd1
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [PIX_W-1:0]        img_q [NPIX];
  state_t                  state_q,     state_d;
  logic [2:0]              row_q,       row_d;
  logic [2:0]              col_q,       col_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_data_q,  out_data_d;
  logic [2:0]              out_row_q,   out_row_d;
  logic [2:0]              out_col_q,   out_col_d;
  logic                    done_q,      done_d;

  logic [5:0]              tap_idx;
  logic signed [ACC_W-1:0] win_sum;

  // All nine taps are read in parallel; {row, col} is the flat image address
  // because the image is exactly 8 pixels wide.
  always_comb begin
    // NOTE: every variable gets a default before any branch or loop so the
    // block stays purely combinational and never infers a latch.
    tap_idx = '0;
    win_sum = '0;
    for (int a = 0; a < K; a++) begin
      for (int b = 0; b < K; b++) begin
        tap_idx = {row_q + 3'(a), col_q + 3'(b)};
        win_sum = win_sum
                + ACC_W'($signed({1'b0, img_q[tap_idx]}))
                * ACC_W'(KERNEL[4'(a * K + b)]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    done_d      = done_q;

    case (state_q)
      IDLE: state_d = RUN;

      RUN: begin
        out_valid_d = 1'b1;
        out_data_d  = win_sum;
        out_row_d   = row_q;
        out_col_d   = col_q;
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          col_d = col_q + 3'd1;
        end
      end

      DONE: begin
        out_valid_d = 1'b0;
        done_d      = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      done_q      <= 1'b0;
      // NOTE: the image has no write port, so reset is its only loader; each
      // reset cycle rewrites pixel(r,c) = r*8 + c, which is just the flat address.
      for (int i = 0; i < NPIX; i++) begin
        img_q[i] <= PIX_W'(i);
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_top.sv
// Directed bench for conv_top: a reference model fills a scoreboard on every reset
// release, and the result stream is popped and compared at each negative clock edge.
module tb_conv_top;

  localparam int N_OUT = 36;

  typedef struct {
    int row;
    int col;
    int data;
  } res_t;

  logic        clk;
  logic        rst;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_row;
  logic [2:0]  out_col;
  logic        done;

  int   n_vec;
  int   n_fail;
  res_t sb[$];
  res_t last_exp;
  int   exp_sum;

  conv_top dut (
    .clk       (clk),
    .rst       (rst),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: pushes the full expected map in emission order.
  task automatic push_expected();
    int   kern [9];
    int   img [8][8];
    res_t e;
    kern    = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    exp_sum = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = r * 8 + c;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        e.row  = i;
        e.col  = j;
        e.data = 0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            e.data += kern[a * 3 + b] * img[i + a][j + b];
        sb.push_back(e);
        exp_sum += e.data;
        last_exp = e;
      end
    end
  endtask

  // Holds reset for n edges from a negedge, checking outputs are cleared after each edge.
  task automatic do_reset(input string tag, input int n);
    rst = 1'b1;
    sb.delete();
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_rst_valid"}, out_valid, 0);
      chk({tag, "_rst_data"},  $signed(out_data), 0);
      chk({tag, "_rst_row"},   out_row, 0);
      chk({tag, "_rst_col"},   out_col, 0);
      chk({tag, "_rst_done"},  done, 0);
    end
    rst = 1'b0;
    push_expected();
  endtask

  // Edge k after reset release: E1 idle, E2..E37 results, E38+ done.
  task automatic run_seq(input string tag, input int n_edges, input bit abort_22);
    res_t e;
    int   sum;
    sum = 0;
    e   = '{0, 0, 0};
    for (int k = 1; k <= n_edges; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_e1_valid"}, out_valid, 0);
        chk({tag, "_e1_done"},  done, 0);
      end else if (k <= N_OUT + 1) begin
        chk({tag, "_run_valid"},    out_valid, 1);
        chk({tag, "_run_done"},     done, 0);
        chk({tag, "_sb_nonempty"},  sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_row"},  out_row, e.row);
          chk({tag, "_col"},  out_col, e.col);
          chk({tag, "_data"}, $signed(out_data), e.data);
          sum += int'($signed(out_data));
          if (abort_22 && e.row == 2 && e.col == 2) return;
        end
      end else begin
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_done"},  done, 1);
        if (k == N_OUT + 2) begin
          chk({tag, "_hold_data"}, $signed(out_data), last_exp.data);
          chk({tag, "_hold_row"},  out_row, last_exp.row);
          chk({tag, "_hold_col"},  out_col, last_exp.col);
        end
      end
    end
    chk({tag, "_sum"},      sum, exp_sum);
    chk({tag, "_sb_drain"}, sb.size(), 0);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst    = 1'b1;

    // Single-cycle reset, then a long free run past DONE.
    do_reset("r1", 1);
    run_seq("free", 100, 1'b0);

    // Multi-cycle reset, then reset again just before (2,3) would be presented.
    do_reset("r5", 5);
    run_seq("pre_mid", 40, 1'b1);
    do_reset("mid", 1);
    run_seq("after_mid", 40, 1'b0);

    // Reset from DONE restarts a full, identically timed sequence.
    do_reset("post_done", 1);
    run_seq("after_done", 40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
